// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, widths, LFSR polynomial, BIST FSM states and
// the golden ALU reference function used by the BIST and future checkers.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CNT_W   = 16;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_SRL = 3'd4;
  localparam logic [OP_W-1:0] OP_SRA = 3'd5;

  localparam logic [DATA_W-1:0] LFSR_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } bist_state_t;

  // Reference result of the ALU for any opcode; unused opcodes yield zero.
  function automatic logic [DATA_W-1:0] alu_golden(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [OP_W-1:0]   op);
    logic [SHAMT_W-1:0] sh;
    sh = b[SHAMT_W-1:0];
    case (op)
      OP_ADD:  return DATA_W'(a + b);
      OP_SUB:  return DATA_W'(a - b);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SRL:  return a >> sh;
      OP_SRA:  return DATA_W'($signed(a) >>> sh);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// 32-bit Galois LFSR (shift right, XOR polynomial on LSB) that advances two
// states per step and exposes both look-ahead states combinationally.
module alu_bist_lfsr
  import alu_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 32'hACE12345
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] step1_c,
  output logic [DATA_W-1:0] step2_c
);

  // An all-zero seed would lock the register at zero forever.
  localparam logic [DATA_W-1:0] SEED_EFF = (SEED == '0) ? DATA_W'(1) : SEED;

  logic [DATA_W-1:0] state;

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  assign step1_c = advance(state);
  assign step2_c = advance(step1_c);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      state <= SEED_EFF;
    end else if (step) begin
      state <= step2_c;
    end
  end

endmodule

// File: rtl/alu_bist.sv
// BIST controller for the 32-bit ALU: drives LFSR operands over all opcodes,
// checks C against the golden model, reports error count and first failure.
// Optional macro ALU_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module alu_bist
  import alu_pkg::*;
#(
  parameter int unsigned       N_VECTORS = 64,
  parameter logic [DATA_W-1:0] LFSR_SEED = 32'hACE12345
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_c
);

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  bist_state_t       state;
  logic [CNT_W-1:0]  idx;
  logic [DATA_W-1:0] step1_c;
  logic [DATA_W-1:0] step2_c;
  logic [OP_W-1:0]   op_c;
  logic              accept_c;
  logic              mismatch_c;
  logic              last_c;

  assign accept_c   = start && ((state == S_IDLE) || (state == S_DONE));
  assign op_c       = idx[OP_W-1:0];
  assign mismatch_c = (alu_c != alu_golden(alu_a, alu_b, alu_op));

`ifdef ALU_BIST_STOP_ON_FAIL_EN
  assign last_c = (idx == IDX_LAST) || mismatch_c;
`else
  assign last_c = (idx == IDX_LAST);
`endif

  alu_bist_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (accept_c),
    .step    (state == S_GEN),
    .step1_c (step1_c),
    .step2_c (step2_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= CNT_MAX;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept_c) begin
            state          <= S_GEN;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= CNT_MAX;
          end
        end
        S_GEN: begin
          alu_a  <= step1_c;
          alu_op <= op_c;
          // Shift opcodes only use B[4:0]; clear the rest to keep B a pure amount.
          if ((op_c == OP_SRL) || (op_c == OP_SRA)) begin
            alu_b <= {{(DATA_W-SHAMT_W){1'b0}}, step2_c[SHAMT_W-1:0]};
          end else begin
            alu_b <= step2_c;
          end
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch_c) begin
            if (err_count != CNT_MAX) begin
              err_count <= err_count + CNT_W'(1);
            end
            if (first_fail_idx == CNT_MAX) begin
              first_fail_idx <= idx;
            end
          end
          if (last_c) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch_c;
          end else begin
            idx   <= idx + CNT_W'(1);
            state <= S_GEN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist with a behavioural ALU that can inject faults.
`timescale 1ns/1ps
module tb_alu_bist;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_fail_idx;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;

  int n_checks = 0;
  int n_errors = 0;
  int fault_mode = 0;  // 0 none, 1 op5 returns 0, 2 op0 inverts bit 0
  int busy_cnt;
  logic [31:0] first_a, first_b, first_op, op4_op, op4_b;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
  localparam int S2_CYC = 12;
  localparam int S2_ERR = 1;
  localparam int S3_CYC = 2;
  localparam int S3_ERR = 1;
`else
  localparam int S2_CYC = 128;
  localparam int S2_ERR = 8;
  localparam int S3_CYC = 128;
  localparam int S3_ERR = 8;
`endif

  alu_bist dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .alu_c          (alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [63:0] ext;
    case (op)
      3'd0: return a + b;
      3'd1: return a + ~b + 32'd1;
      3'd2: return ~(~a | ~b);
      3'd3: return ~(~a & ~b);
      3'd4: begin ext = {32'h0, a} >> b[4:0]; return ext[31:0]; end
      3'd5: begin ext = {{32{a[31]}}, a} >> b[4:0]; return ext[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    alu_c = ref_alu(alu_a, alu_b, alu_op);
    if (fault_mode == 1 && alu_op == 3'd5) alu_c = 32'h0;
    if (fault_mode == 2 && alu_op == 3'd0) alu_c = alu_c ^ 32'h1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start, then count edges until done; optional second start pulse mid-run.
  task automatic run(input int pulse_at, output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_accept", 32'(busy), 32'd1);
    check("done_on_accept", 32'(done), 32'd0);
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 2000) begin
      @(posedge clk); #1;
      cycles++;
      if (busy) busy_cnt++;
      if (cycles == 1) begin
        first_a = alu_a; first_b = alu_b; first_op = 32'(alu_op);
      end
      if (cycles == 9) begin
        op4_op = 32'(alu_op); op4_b = alu_b;
      end
      start = (pulse_at != 0 && cycles == pulse_at);
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag, input int cyc, input int exp_cyc,
                              input int exp_err, input int exp_ff);
    check({tag, "_cycles"},   32'(cyc),            32'(exp_cyc));
    check({tag, "_busy_cnt"}, 32'(busy_cnt),       32'(exp_cyc - 1));
    check({tag, "_busy"},     32'(busy),           32'd0);
    check({tag, "_done"},     32'(done),           32'd1);
    check({tag, "_err"},      32'(err_count),      32'(exp_err));
    check({tag, "_ffidx"},    32'(first_fail_idx), 32'(exp_ff));
    check({tag, "_pass"},     32'(pass),           (exp_err == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   32'(busy),           32'd0);
    check({tag, "_done"},   32'(done),           32'd0);
    check({tag, "_pass"},   32'(pass),           32'd0);
    check({tag, "_err"},    32'(err_count),      32'd0);
    check({tag, "_ffidx"},  32'(first_fail_idx), 32'h0000FFFF);
    check({tag, "_alu_a"},  alu_a,               32'd0);
    check({tag, "_alu_b"},  alu_b,               32'd0);
    check({tag, "_alu_op"}, 32'(alu_op),         32'd0);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Golden-model spot checks, including arithmetic shift sign fill.
    check("pkg_sra",  alu_pkg::alu_golden(32'hFFFF0000, 32'd3, 3'd5), 32'hFFFFE000);
    check("pkg_sub",  alu_pkg::alu_golden(32'd5, 32'd7, 3'd1),        32'hFFFFFFFE);
    check("pkg_op7",  alu_pkg::alu_golden(32'h1234, 32'h1, 3'd7),      32'h0);

    // Scenario 1: clean ALU.
    fault_mode = 0;
    run(0, cyc);
    check_result("s1", cyc, 128, 0, 16'hFFFF);
    check("s1_first_a",  first_a,  32'hD65091A1);
    check("s1_first_b",  first_b,  32'hEB0848D3);
    check("s1_first_op", first_op, 32'd0);
    check("s1_op4_op",   op4_op,   32'd4);
    check("s1_op4_bhi",  op4_b >> 5, 32'd0);

    // Scenario 2: op 101 broken.
    fault_mode = 1;
    run(0, cyc);
    check_result("s2", cyc, S2_CYC, S2_ERR, 5);

    // Scenario 3: op 000 bit 0 inverted, then rerun with identical vectors.
    fault_mode = 2;
    run(0, cyc);
    check_result("s3a", cyc, S3_CYC, S3_ERR, 0);
    run(0, cyc);
    check_result("s3b", cyc, S3_CYC, S3_ERR, 0);
    check("s3b_first_a", first_a, 32'hD65091A1);

    // Scenario 4: reset in GEN of vector 10 aborts the run.
    fault_mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("s4_abort");
    reset = 1'b0;
    fault_mode = 0;
    run(0, cyc);
    check_result("s4_rerun", cyc, 128, 0, 16'hFFFF);

    // Scenario 5: start while busy is ignored.
    run(50, cyc);
    check_result("s5", cyc, 128, 0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test controller for the 32-bit combinational ALU (ports A, B, ALUOp[2:0], C).
- Acts as the initiator to the ALU: generates pseudo-random operand pairs, walks all eight ALUOp codes, samples C and compares it against an internal golden model.
- Reports the mismatch count and the first failing vector.
- Sits beside the ALU in P1 and is reused by later datapath stages for power-on checking.

Parameters:
- N_VECTORS, 64: number of vectors per run; legal range 1..65535.
- LFSR_SEED, 32'hACE12345: initial LFSR state; a value of 0 is replaced by 32'h1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start or reset.
- pass  out  1  equals done AND (err_count == 0).
- err_count  out  16  number of mismatching vectors; saturates at 16'hFFFF.
- first_fail_idx  out  16  index of the first mismatching vector; 16'hFFFF if none.
- alu_a  out  32  drives ALU input A.
- alu_b  out  32  drives ALU input B.
- alu_op  out  3  drives ALU input ALUOp.
- alu_c  in  32  ALU result C.

Behaviour:
- Reset: synchronous, active-high. On a reset edge every output goes to 0 except first_fail_idx, which goes to 16'hFFFF. FSM returns to IDLE, LFSR reloads LFSR_SEED, vector index clears to 0. Reset mid-run aborts the run; no partial result is kept.
- FSM states: IDLE, GEN, CHECK, DONE.
  - IDLE/DONE -> GEN on start. At that edge: err_count cleared, first_fail_idx set to FFFF, index cleared to 0, LFSR reloaded with the seed, busy set to 1, done cleared to 0.
  - GEN (1 cycle): LFSR advances twice. First new state goes to alu_a, second to alu_b. alu_op = idx[2:0]. For alu_op 4 or 5, alu_b[31:5] is forced to 0. All three outputs are registered.
  - CHECK (1 cycle): alu_c is compared with golden(alu_a, alu_b, alu_op).
    - On mismatch: err_count increments (saturating). If first_fail_idx == FFFF, it takes idx.
    - If idx == N_VECTORS-1 -> DONE; otherwise idx increments -> GEN.
  - DONE: busy = 0, done = 1. alu_a, alu_b and alu_op hold their last values.
- Start while busy is ignored.
- Timing: each vector takes 2 cycles. done rises exactly 2*N_VECTORS cycles after the edge that accepts start.
- Golden model, 32-bit wrap-around:
  - 000: A+B
  - 001: A-B
  - 010: A&B
  - 011: A|B
  - 100: A>>B[4:0] (logical)
  - 101: $signed(A)>>>B[4:0] (arithmetic)
  - 110 and 111: 32'h0
- LFSR: 32-bit Galois, polynomial 32'h80200003; shift right, XOR the polynomial when the LSB is 1. Never reaches 0.

Optional Feature:
- Macro: ALU_BIST_STOP_ON_FAIL_EN.
- Defined: a mismatch in CHECK goes directly to DONE, so err_count is at most 1.
- Undefined: the run always completes all N_VECTORS vectors.

Decomposition:
- Package alu_pkg:
  - ALU opcode constants OP_ADD..OP_SRA.
  - DATA_W = 32.
  - LFSR_POLY.
  - Function alu_golden(a, b, op), shared with future checkers.
- Sub-module alu_bist_lfsr: 32-bit Galois LFSR with load, step and a two-step output, instantiated once.

Test Plan:
1. Golden ALU connected, N_VECTORS=64, start pulse -> busy for 128 cycles, then done=1, pass=1, err_count=0, first_fail_idx=FFFF.
2. Faulty ALU returns 0 for op 101, N=64 -> err_count=8, first_fail_idx=5, pass=0. Also spot-check that the model yields 32'hFFFFE000 for A=FFFF0000, B=3, op=101.
3. Faulty ALU inverts bit 0 for op 000 -> err_count=8, first_fail_idx=0. A second start then reruns with identical vectors (seed reload) and again gives err_count=8.
4. Reset asserted in GEN of vector 10 -> on the next edge busy=0, done=0, err_count=0, alu_a/alu_b/alu_op=0, first_fail_idx=FFFF. A fresh start then gives the result of scenario 1.
5. Start pulsed again during busy -> no restart; done still occurs at cycle 128.
6. ALU_BIST_STOP_ON_FAIL_EN defined with the scenario-2 fault -> done 12 cycles after start, err_count=1, first_fail_idx=5.
